// File: rtl/apb_initiator_pkg.sv
// apb_initiator_pkg: FSM state encoding and watchdog sizing for the APB initiator
package apb_initiator_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_init_state_e;
  localparam int unsigned WDOG_MIN_W = 8;
  localparam int unsigned WDOG_MAX_W = 32;
  function automatic int unsigned wdog_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return w < WDOG_MIN_W ? WDOG_MIN_W : (w > WDOG_MAX_W ? WDOG_MAX_W : w);
  endfunction
endpackage

// File: rtl/apb_init_wdog.sv
// apb_init_wdog: ACCESS-phase wait counter; expire flags the last permitted wait cycle
module apb_init_wdog #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned W     = 8
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic load,
  input  logic count,
  output logic expire
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? '0 : (count ? cnt_q + W'(1) : cnt_q);
  always_ff @(posedge PCLK) begin
    if (!PRESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
  assign expire = cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/apb_initiator.sv
// apb_initiator: single-outstanding APB requester with vld/rdy command and response channels.
// Define APB_INIT_TIMEOUT_EN to enable the ACCESS-phase watchdog abort.
module apb_initiator
  import apb_initiator_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;
  apb_init_state_e state_q, state_d;
  logic psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  rsp_t rsp_q, rsp_d;
  logic abort;
`ifdef APB_INIT_TIMEOUT_EN
  logic wdog_expire;
  apb_init_wdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (wdog_width(TIMEOUT_CYCLES))
  ) u_wdog (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .load    (state_q == SETUP),
    .count   (state_q == ACCESS && !PREADY),
    .expire  (wdog_expire)
  );
  assign abort = wdog_expire && state_q == ACCESS && !PREADY;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = |TIMEOUT_CYCLES;
  assign abort = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rsp_d     = rsp_q;
    case (state_q)
      IDLE: if (cmd_vld) begin
        state_d  = SETUP;
        psel_d   = 1'b1;
        pwrite_d = cmd_wr;
        paddr_d  = cmd_addr;
        pwdata_d = cmd_wdata;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      // a ready completer always beats a same-cycle watchdog expiry
      ACCESS: if (PREADY || abort) begin
        state_d       = RESP;
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        rsp_d.rdata   = (PREADY && !pwrite_q) ? PRDATA : '0;
        rsp_d.err     = PREADY ? PSLVERR : 1'b1;
        rsp_d.timeout = !PREADY;
      end
      RESP: if (rsp_rdy) begin
        state_d = IDLE;
        rsp_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rsp_q     <= rsp_d;
    end
  end
  assign cmd_rdy     = state_q == IDLE;
  assign rsp_vld     = state_q == RESP;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
endmodule
